// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Opcodes, control encodings and pipelined control-word types for
//          the RV32I five-stage pipeline control path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_t;

  typedef struct packed {
    logic reg_write;
    res_t result_src;
    logic mem_write;
    logic jump;
    logic branch;
    alu_t alu_control;
    logic alu_src_a;
    logic alu_src_b;
    logic funct3_0;
  } ctrl_t;

  typedef struct packed {
    logic reg_write;
    res_t result_src;
    logic mem_write;
  } ctrl_m_t;

  typedef struct packed {
    logic reg_write;
    res_t result_src;
  } ctrl_w_t;

  // funct3 to ALU op; 'sub' is only honoured for funct3=000 (R-type sub)
  function automatic alu_t alu_decode(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  alu_decode = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_decode = ALU_AND;
      3'b110:  alu_decode = ALU_OR;
      3'b100:  alu_decode = ALU_XOR;
      3'b010:  alu_decode = ALU_SLT;
      3'b001:  alu_decode = ALU_SLL;
      3'b101:  alu_decode = ALU_SRL;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_unit.sv
// ============================================================================
// Module : hazard_unit
// Brief  : Forwarding selects, load-use stall and branch flush generation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_unit
  import riscv_pkg::*;
(
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  res_t       ResultSrcE,
  input  logic       PCSrcE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE
);

  logic w_lw_stall;

  // M-stage result is newer than W, so it wins when both match
  always_comb begin
    ForwardAE = 2'b00;
    if (Rs1E != 5'd0 && RegWriteM && Rs1E == RdM)
      ForwardAE = 2'b10;
    else if (Rs1E != 5'd0 && RegWriteW && Rs1E == RdW)
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (Rs2E != 5'd0 && RegWriteM && Rs2E == RdM)
      ForwardBE = 2'b10;
    else if (Rs2E != 5'd0 && RegWriteW && Rs2E == RdW)
      ForwardBE = 2'b01;
  end

  assign w_lw_stall = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

  assign StallF = w_lw_stall;
  assign StallD = w_lw_stall;
  assign FlushD = PCSrcE;
  assign FlushE = w_lw_stall | PCSrcE;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module : pipe_ctrl
// Brief  : RV32I decode, D/E/M/W control pipeline and hazard sequencing.
//          Optional perf counters enabled by PIPE_CTRL_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opD,
  input  logic [2:0]  funct3D,
  input  logic        funct7b5D,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        ZeroE,
  output logic [2:0]  ImmSrcD,
  output logic [2:0]  ALUControlE,
  output logic        ALUSrcAE,
  output logic        ALUSrcBE,
  output logic        PCSrcE,
  output logic        MemWriteM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  ctrl_t   w_ctrl_d;
  imm_t    w_imm_src;
  ctrl_t   r_ctrl_e;
  ctrl_m_t r_ctrl_m;
  ctrl_w_t r_ctrl_w;

  always_comb begin
    w_ctrl_d  = '0;
    w_imm_src = IMM_I;
    case (opD)
      OP_LOAD: begin
        w_ctrl_d.reg_write  = 1'b1;
        w_ctrl_d.result_src = RES_MEM;
        w_ctrl_d.alu_src_b  = 1'b1;
      end
      OP_STORE: begin
        w_ctrl_d.mem_write = 1'b1;
        w_ctrl_d.alu_src_b = 1'b1;
        w_imm_src          = IMM_S;
      end
      OP_R: begin
        w_ctrl_d.reg_write   = 1'b1;
        w_ctrl_d.alu_control = alu_decode(funct3D, funct7b5D);
      end
      OP_I: begin
        w_ctrl_d.reg_write   = 1'b1;
        w_ctrl_d.alu_src_b   = 1'b1;
        w_ctrl_d.alu_control = alu_decode(funct3D, 1'b0);
      end
      OP_BRANCH: begin
        w_imm_src = IMM_B;
        // only beq/bne are supported; other branch funct3 become bubbles
        if (funct3D[2:1] == 2'b00) begin
          w_ctrl_d.branch      = 1'b1;
          w_ctrl_d.alu_control = ALU_SUB;
          w_ctrl_d.funct3_0    = funct3D[0];
        end
      end
      OP_JAL: begin
        w_ctrl_d.reg_write  = 1'b1;
        w_ctrl_d.jump       = 1'b1;
        w_ctrl_d.result_src = RES_PC4;
        w_imm_src           = IMM_J;
      end
      OP_LUI: begin
        w_ctrl_d.reg_write = 1'b1;
        w_ctrl_d.alu_src_a = 1'b1;
        w_ctrl_d.alu_src_b = 1'b1;
        w_imm_src          = IMM_U;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl_e <= '0;
      r_ctrl_m <= '0;
      r_ctrl_w <= '0;
    end else begin
      r_ctrl_e <= FlushE ? '0 : w_ctrl_d;
      r_ctrl_m <= '{reg_write:  r_ctrl_e.reg_write,
                    result_src: r_ctrl_e.result_src,
                    mem_write:  r_ctrl_e.mem_write};
      r_ctrl_w <= '{reg_write:  r_ctrl_m.reg_write,
                    result_src: r_ctrl_m.result_src};
    end
  end

  assign ImmSrcD     = w_imm_src;
  assign ALUControlE = r_ctrl_e.alu_control;
  assign ALUSrcAE    = r_ctrl_e.alu_src_a;
  assign ALUSrcBE    = r_ctrl_e.alu_src_b;
  assign PCSrcE      = r_ctrl_e.jump | (r_ctrl_e.branch & (ZeroE ^ r_ctrl_e.funct3_0));
  assign MemWriteM   = r_ctrl_m.mem_write;
  assign RegWriteW   = r_ctrl_w.reg_write;
  assign ResultSrcW  = r_ctrl_w.result_src;

  hazard_unit u_hazard (
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (r_ctrl_m.reg_write),
    .RegWriteW  (r_ctrl_w.reg_write),
    .ResultSrcE (r_ctrl_e.result_src),
    .PCSrcE     (PCSrcE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // StallF is exactly the load-use stall condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallF && r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (PCSrcE && r_flush_cnt != 32'hFFFF_FFFF)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module : tb_pipe_ctrl
// Brief  : Directed self-checking bench for pipe_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opD;
  logic [2:0]  funct3D;
  logic        funct7b5D;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        ZeroE;
  logic [2:0]  ImmSrcD, ALUControlE;
  logic        ALUSrcAE, ALUSrcBE, PCSrcE, MemWriteM, RegWriteW;
  logic [1:0]  ResultSrcW, ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ZeroE(ZeroE), .ImmSrcD(ImmSrcD), .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE),
    .ALUSrcBE(ALUSrcBE), .PCSrcE(PCSrcE), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    opD = op; funct3D = f3; funct7b5D = f7; Rs1D = rs1; Rs2D = rs2;
  endtask

  task automatic set_e(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [4:0] rdm, input logic [4:0] rdw);
    Rs1E = rs1; Rs2E = rs2; RdE = rd; RdM = rdm; RdW = rdw;
  endtask

  initial begin
    reset = 1'b1; ZeroE = 1'b0;
    set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
    set_e(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    #2;
    chk("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
    chk("rst_alu", {29'd0, ALUControlE}, 32'd0);
    chk("rst_fwd", {28'd0, ForwardAE, ForwardBE}, 32'd0);
    chk("rst_haz", {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    chk("rst_w", {28'd0, RegWriteW, MemWriteM, ResultSrcW}, 32'd0);

    // immediate select is combinational from the opcode
    set_d(7'b0100011, 3'd2, 1'b0, 5'd0, 5'd0); #1 chk("imm_s", {29'd0, ImmSrcD}, 32'd1);
    set_d(7'b1100011, 3'd0, 1'b0, 5'd0, 5'd0); #1 chk("imm_b", {29'd0, ImmSrcD}, 32'd2);
    set_d(7'b1101111, 3'd0, 1'b0, 5'd0, 5'd0); #1 chk("imm_j", {29'd0, ImmSrcD}, 32'd3);
    set_d(7'b0110111, 3'd0, 1'b0, 5'd0, 5'd0); #1 chk("imm_u", {29'd0, ImmSrcD}, 32'd4);
    set_d(7'b0000011, 3'd2, 1'b0, 5'd0, 5'd0); #1 chk("imm_i", {29'd0, ImmSrcD}, 32'd0);
    set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
    tick();
    reset = 1'b0;
    tick();

    // add x3,x1,x2 ; sub x4,x3,x1
    set_d(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2);
    tick();
    set_e(5'd1, 5'd2, 5'd3, 5'd0, 5'd0);
    set_d(7'b0110011, 3'd0, 1'b1, 5'd3, 5'd1);
    #1;
    chk("add_alu", {29'd0, ALUControlE}, 32'd0);
    chk("add_srcb", {31'd0, ALUSrcBE}, 32'd0);
    chk("add_nostall", {31'd0, StallF}, 32'd0);
    tick();
    set_e(5'd3, 5'd1, 5'd4, 5'd3, 5'd0);
    set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("sub_fwda", {30'd0, ForwardAE}, 32'd2);
    chk("sub_fwdb", {30'd0, ForwardBE}, 32'd0);
    chk("sub_alu", {29'd0, ALUControlE}, 32'd1);
    tick();
    set_e(5'd3, 5'd0, 5'd0, 5'd4, 5'd3);
    #1;
    chk("wb_fwda", {30'd0, ForwardAE}, 32'd1);
    chk("add_regw", {31'd0, RegWriteW}, 32'd1);
    chk("add_ressrc", {30'd0, ResultSrcW}, 32'd0);
    tick(); tick();

    // lw x5,0(x0) ; add x6,x5,x1
    set_e(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    set_d(7'b0000011, 3'd2, 1'b0, 5'd0, 5'd0);
    tick();
    set_e(5'd0, 5'd0, 5'd5, 5'd0, 5'd0);
    set_d(7'b0110011, 3'd0, 1'b0, 5'd5, 5'd1);
    #1;
    chk("lw_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
    chk("lw_noflushd", {31'd0, FlushD}, 32'd0);
    chk("lw_srcb", {31'd0, ALUSrcBE}, 32'd1);
    tick();
    set_e(5'd0, 5'd0, 5'd5, 5'd5, 5'd0);
    #1;
    chk("lw_stall_once", {29'd0, StallF, StallD, FlushE}, 32'd0);
    tick();
    set_e(5'd5, 5'd1, 5'd6, 5'd0, 5'd5);
    set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("use_fwda", {30'd0, ForwardAE}, 32'd1);
    chk("use_fwdb", {30'd0, ForwardBE}, 32'd0);
    chk("lw_ressrc", {30'd0, ResultSrcW}, 32'd1);
    tick(); tick(); tick();

    // beq taken, then bne not taken with ZeroE=1
    set_e(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    set_d(7'b1100011, 3'd0, 1'b0, 5'd1, 5'd2);
    tick();
    set_d(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd2);
    ZeroE = 1'b1;
    #1;
    chk("beq_pcsrc", {31'd0, PCSrcE}, 32'd1);
    chk("beq_flush", {30'd0, FlushD, FlushE}, 32'd3);
    chk("beq_nostall", {31'd0, StallF}, 32'd0);
    chk("beq_alu", {29'd0, ALUControlE}, 32'd1);
    tick();
    set_d(7'b1100011, 3'd1, 1'b0, 5'd1, 5'd2);
    #1;
    chk("beq_flush_once", {29'd0, PCSrcE, FlushD, FlushE}, 32'd0);
    tick();
    set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("bne_z1", {29'd0, PCSrcE, FlushD, FlushE}, 32'd0);
    ZeroE = 1'b0;
    #1;
    chk("bne_z0", {31'd0, PCSrcE}, 32'd1);
    tick();
    tick();

    // x0 is never forwarded or stalled on
    set_d(7'b0010011, 3'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_e(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("x0_fwd", {30'd0, ForwardAE}, 32'd0);
    set_d(7'b0000011, 3'd2, 1'b0, 5'd0, 5'd0);
    tick();
    set_d(7'b0110011, 3'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("x0_nostall", {31'd0, StallF}, 32'd0);
    set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
    tick(); tick(); tick();

    // async reset with sw in M and jal in E
    set_d(7'b0100011, 3'd2, 1'b0, 5'd0, 5'd1);
    tick();
    set_d(7'b1101111, 3'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("pre_memw", {31'd0, MemWriteM}, 32'd1);
    chk("pre_jal", {31'd0, PCSrcE}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_memw", {31'd0, MemWriteM}, 32'd0);
    chk("arst_pcsrc", {30'd0, PCSrcE, FlushE}, 32'd0);
    chk("arst_cnt", stall_cnt | flush_cnt, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("restart_bubble", {30'd0, RegWriteW, MemWriteM}, 32'd0);

    // three load-use pairs and two taken branches
    for (int i = 0; i < 3; i++) begin
      set_e(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      set_d(7'b0000011, 3'd2, 1'b0, 5'd0, 5'd0);
      tick();
      set_e(5'd0, 5'd0, 5'd5, 5'd0, 5'd0);
      set_d(7'b0110011, 3'd0, 1'b0, 5'd1, 5'd5);
      tick();
      set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
      set_e(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_d(7'b1100011, 3'd0, 1'b0, 5'd1, 5'd2);
      tick();
      set_d(7'b0000000, 3'd0, 1'b0, 5'd0, 5'd0);
      ZeroE = 1'b1;
      tick();
      ZeroE = 1'b0;
    end
    tick();
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("flush_cnt", flush_cnt, 32'd2);
`else
    chk("stall_cnt", stall_cnt, 32'd0);
    chk("flush_cnt", flush_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
